lcd_text_writer: RTL
====================

Name: lcd_text_writer

Overview:
- Writer side of the LCD display buffer. The CPU issues memory-mapped stores, and this block turns them into 9-bit display entries ({RS=1, ASCII}) in a 32-entry character buffer.
- The LCD sequencer scans the buffer through a combinational read port (rd_addr/rd_data), using the same addressing it uses for its data window.
- The block supports single-character writes, hex printing of a 32-bit word (8 characters serialised by an FSM), and a whole-buffer clear.

Parameters:
- BUF_DEPTH, 32, number of character cells; the cursor wraps modulo BUF_DEPTH (power of two).
- BASE_ADDR, 6, value of rd_addr that maps to cell 0.

Ports:
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-low
- cpu_we  input  1  write strobe; one accepted write per cycle
- cpu_addr  input  3  register select: 0 CURSOR, 1 CHAR, 2 HEX, 3 CLEAR; 4-7 reserved
- cpu_wdata  input  32  write data
- cpu_rdata  output  32  status: [5:0] cursor, [8] busy, [9] ovf, others 0 (combinational)
- busy  output  1  high while the HEX or CLR state is active
- rd_addr  input  6  LCD read address
- rd_data  output  9  buf[rd_addr-BASE_ADDR] when BASE_ADDR <= rd_addr < BASE_ADDR+BUF_DEPTH; otherwise 9'h120 (combinational)

Behaviour:
- States: IDLE, HEX, CLR.
- Reset (rst low at a clock edge):
  - state goes to CLR, clear index=0, cursor=0, ovf=0, nibble count=0.
  - No buffer writes occur while rst is low; busy=1 and cpu_rdata={ovf=0, busy=1, cursor=0}.
- After rst releases, CLR writes 9'h120 to cells 0..31, one per cycle over 32 cycles, then goes to IDLE. busy drops in the cycle after the cell-31 write.
- rst asserted mid-operation aborts HEX or CLR; the full clear restarts on release.
- Writes in IDLE (effect at the accepting edge):
  - CURSOR: cursor <= wdata[4:0]; ovf <= 0.
  - CHAR: buf[cursor] <= {1'b1, wdata[7:0]}; cursor <= cursor+1 mod 32. The new cell is visible on rd_data next cycle.
  - HEX: latch wdata, go to HEX. busy=1 for the next 8 cycles. Each cycle writes one nibble, MSB first, to buf[cursor] and increments cursor (with wrap). After the 8th write, go to IDLE.
  - CLEAR: go to CLR, clear index=0, cursor <= 0. The clear takes 32 cycles with busy=1.
- Nibble to ASCII conversion: 0-9 -> 0x30+n; A-F -> 0x41+(n-10). Stored as {1'b1, ascii}.
- A cpu_we while busy=1 is dropped: no state or buffer change, and ovf <= 1 (sticky until a CURSOR write or reset).
- Reserved addresses 4-7 are ignored in all states.
- Cursor wrap: a HEX starting at cursor 28 writes cells 28..31 then 0..3 and ends with cursor=4.
- Read/write same cell same cycle: rd_data shows the old value; the new value appears the next cycle.

Decomposition:
- Package lcd_pkg contents:
  - state enum {IDLE, HEX, CLR}
  - register selects REG_CURSOR=0, REG_CHAR=1, REG_HEX=2, REG_CLEAR=3
  - SPACE_CHAR=9'h120
  - function nib2ascii
- Sub-module lcd_char_ram: BUF_DEPTH x 9, one synchronous write port, one asynchronous read port.
- FSM, cursor, nibble counter and status logic live in lcd_text_writer.

Test Plan:
- Release rst after 3 low cycles -> busy=1 for exactly 32 cycles. Then rd_addr=6..37 all return 9'h120, rd_addr=5 returns 9'h120, cursor=0.
- CURSOR=0, then CHAR 0x48 and CHAR 0x69 -> rd_addr 6 = 9'h148, rd_addr 7 = 9'h169, cpu_rdata[5:0]=2, busy stays 0.
- CURSOR=10, HEX 0xDEADBEEF -> busy=1 for 8 cycles. Cells 10..17 = 0x144,0x145,0x141,0x144,0x142,0x145,0x145,0x146; cursor=18.
- CURSOR=28, HEX 0x01234567 -> cells 28..31 = '0','1','2','3' and cells 0..3 = '4','5','6','7'; cursor=4 after wrap.
- CHAR 0x41 issued in the 3rd busy cycle of a HEX -> CHAR dropped, ovf=1, HEX result intact. A later CURSOR write clears ovf to 0.
- rst low during the 5th HEX cycle -> on release a full 32-cycle clear runs, all cells end at 9'h120, cursor=0, ovf=0.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, register selects and helpers for the LCD text writer
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEX  = 2'd1,
    CLR  = 2'd2
  } state_t;

  localparam logic [2:0] REG_CURSOR = 3'd0;
  localparam logic [2:0] REG_CHAR   = 3'd1;
  localparam logic [2:0] REG_HEX    = 3'd2;
  localparam logic [2:0] REG_CLEAR  = 3'd3;

  localparam logic [8:0] SPACE_CHAR = 9'h120;

  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
  endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// rtl/lcd_char_ram.sv - character cell storage, synchronous write, asynchronous read
module lcd_char_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 9,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_text_writer.sv
// rtl/lcd_text_writer.sv - turns CPU register stores into display cells (char, hex word, clear)
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter int BUF_DEPTH = 32,
  parameter int BASE_ADDR = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        busy,
  input  logic [5:0]  rd_addr,
  output logic [8:0]  rd_data
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [6:0] RD_LO = 7'(BASE_ADDR);
  localparam logic [6:0] RD_HI = 7'(BASE_ADDR + BUF_DEPTH);

  state_t        state, state_nx;
  logic [AW-1:0] cursor, cursor_nx;
  logic [AW-1:0] clr_idx, clr_idx_nx;
  logic [2:0]    nib_cnt, nib_cnt_nx;
  logic [31:0]   hex_data, hex_data_nx;
  logic          ovf, ovf_nx;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [8:0]    ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [8:0]    ram_rdata;
  logic [6:0]    rd_ext;
  logic          rd_hit;
  logic          acc_we;

  // Reserved selects never count as writes, so they cannot raise ovf either.
  assign acc_we = cpu_we && (cpu_addr < 3'd4);
  assign busy   = (state != IDLE);

  always_comb begin
    state_nx    = state;
    cursor_nx   = cursor;
    clr_idx_nx  = clr_idx;
    nib_cnt_nx  = nib_cnt;
    hex_data_nx = hex_data;
    ovf_nx      = ovf;
    ram_we      = 1'b0;
    ram_waddr   = cursor;
    ram_wdata   = SPACE_CHAR;
    case (state)
      IDLE: begin
        if (acc_we) begin
          case (cpu_addr)
            REG_CURSOR: begin
              cursor_nx = cpu_wdata[AW-1:0];
              ovf_nx    = 1'b0;
            end
            REG_CHAR: begin
              ram_we    = 1'b1;
              ram_wdata = {1'b1, cpu_wdata[7:0]};
              cursor_nx = cursor + 1'b1;
            end
            REG_HEX: begin
              hex_data_nx = cpu_wdata;
              nib_cnt_nx  = 3'd0;
              state_nx    = HEX;
            end
            REG_CLEAR: begin
              clr_idx_nx = '0;
              cursor_nx  = '0;
              state_nx   = CLR;
            end
            default: ;
          endcase
        end
      end
      HEX: begin
        // Shift left so the next nibble to print is always in the top four bits.
        ram_we      = 1'b1;
        ram_wdata   = {1'b1, nib2ascii(hex_data[31:28])};
        hex_data_nx = {hex_data[27:0], 4'h0};
        cursor_nx   = cursor + 1'b1;
        nib_cnt_nx  = nib_cnt + 1'b1;
        if (nib_cnt == 3'd7) state_nx = IDLE;
        if (acc_we) ovf_nx = 1'b1;
      end
      CLR: begin
        ram_we     = 1'b1;
        ram_waddr  = clr_idx;
        clr_idx_nx = clr_idx + 1'b1;
        if (clr_idx == AW'(BUF_DEPTH - 1)) state_nx = IDLE;
        if (acc_we) ovf_nx = 1'b1;
      end
      default: state_nx = CLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= CLR;
      cursor   <= '0;
      clr_idx  <= '0;
      nib_cnt  <= 3'd0;
      hex_data <= 32'd0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nx;
      cursor   <= cursor_nx;
      clr_idx  <= clr_idx_nx;
      nib_cnt  <= nib_cnt_nx;
      hex_data <= hex_data_nx;
      ovf      <= ovf_nx;
    end
  end

  assign rd_ext    = {1'b0, rd_addr};
  assign rd_hit    = (rd_ext >= RD_LO) && (rd_ext < RD_HI);
  assign ram_raddr = AW'(rd_ext - RD_LO);
  assign rd_data   = rd_hit ? ram_rdata : SPACE_CHAR;
  assign cpu_rdata = {22'd0, ovf, busy, 2'd0, 6'(cursor)};

  lcd_char_ram #(
    .DEPTH(BUF_DEPTH),
    .WIDTH(9),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we && rst),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

endmodule
